// File: rtl/dds_freq_meter.sv
// rtl/dds_freq_meter.sv - zero-crossing frequency meter recovering a DDS fcw; DDS_FM_HYST_EN adds crossing hysteresis
module dds_freq_meter #(
    parameter int LOG2_NCYC = 4,
    parameter int CNT_W     = 24,
    parameter int HYST      = 256
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic signed [15:0] sin_amp,
    input  logic               amp_valid,
    output logic [31:0]        fcw_est,
    output logic [CNT_W-1:0]   period_t,
    output logic               meas_valid,
    output logic               locked,
    output logic               timeout,
    output logic               busy
);
    localparam int NUM_W  = 33 + LOG2_NCYC;
    localparam int XCNT_W = LOG2_NCYC + 1;
    localparam int DCNT_W = $clog2(NUM_W);

    localparam logic [XCNT_W-1:0] N_CYC    = XCNT_W'(1 << LOG2_NCYC);
    localparam logic [XCNT_W-1:0] XCNT_ONE = XCNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]    T_ONE    = (CNT_W+1)'(1);
    localparam logic [DCNT_W-1:0] DCNT_TOP = DCNT_W'(NUM_W - 1);
    localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_DIVIDE  = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              prev_neg_q, prev_neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XCNT_W-1:0] xcnt_q, xcnt_d;
    logic [CNT_W:0]    t_q, t_d;
    logic [CNT_W:0]    rem_q, rem_d;
    logic [NUM_W-1:0]  quo_q, quo_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [31:0]       fcw_q, fcw_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              meas_valid_q, meas_valid_d;
    logic              locked_q, locked_d;
    logic              timeout_q, timeout_d;

    logic              amp_neg;
    logic              xing;
    logic              num_bit;
    logic [CNT_W+1:0]  rem_shift;
    logic [CNT_W+1:0]  rem_sub;
    logic              rem_ge;
    logic [NUM_W-1:0]  quo_next;

    assign amp_neg = (sin_amp < 16'sd0);

`ifdef DDS_FM_HYST_EN
    localparam logic signed [15:0] HYST_NEG = 16'(-HYST);
    logic arm_q, arm_d;

    assign xing = amp_valid && prev_neg_q && !amp_neg && arm_q;

    // Arm on a deep negative excursion; a counted crossing disarms until the next one.
    always_comb begin
        arm_d = arm_q;
        if (amp_valid) begin
            if (sin_amp < HYST_NEG) begin
                arm_d = 1'b1;
            end else if (xing) begin
                arm_d = 1'b0;
            end
        end
    end
`else
    assign xing = amp_valid && prev_neg_q && !amp_neg;
`endif

    // Numerator is a single one at its MSB followed by zeros.
    assign num_bit   = (dcnt_q == DCNT_TOP);
    assign rem_shift = {rem_q, num_bit};
    assign rem_ge    = (rem_shift >= {1'b0, t_q});
    assign rem_sub   = rem_shift - {1'b0, t_q};
    assign quo_next  = {quo_q[NUM_W-2:0], rem_ge};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        xcnt_d       = xcnt_q;
        t_d          = t_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dcnt_d       = dcnt_q;
        fcw_d        = fcw_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        timeout_d    = 1'b0;
        prev_neg_d   = amp_valid ? amp_neg : prev_neg_q;

        case (state_q)
            S_IDLE: begin
                if (xing) begin
                    cnt_d   = '0;
                    xcnt_d  = '0;
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (amp_valid) begin
                    if (xing && (xcnt_q + XCNT_ONE == N_CYC)) begin
                        t_d     = {1'b0, cnt_q} + T_ONE;
                        rem_d   = '0;
                        quo_d   = '0;
                        dcnt_d  = DCNT_TOP;
                        state_d = S_DIVIDE;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (xing) begin
                            xcnt_d = xcnt_q + XCNT_ONE;
                        end
                    end
                end
            end
            S_DIVIDE: begin
                rem_d  = rem_ge ? rem_sub[CNT_W:0] : rem_shift[CNT_W:0];
                quo_d  = quo_next;
                dcnt_d = dcnt_q - DCNT_ONE;
                if (dcnt_q == '0) begin
                    fcw_d        = (|quo_next[NUM_W-1:32]) ? 32'hFFFF_FFFF : quo_next[31:0];
                    period_d     = t_q[CNT_W-1:0];
                    meas_valid_d = 1'b1;
                    locked_d     = 1'b1;
                    state_d      = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            prev_neg_q   <= 1'b0;
            cnt_q        <= '0;
            xcnt_q       <= '0;
            t_q          <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dcnt_q       <= '0;
            fcw_q        <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef DDS_FM_HYST_EN
            arm_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            prev_neg_q   <= prev_neg_d;
            cnt_q        <= cnt_d;
            xcnt_q       <= xcnt_d;
            t_q          <= t_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dcnt_q       <= dcnt_d;
            fcw_q        <= fcw_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
`ifdef DDS_FM_HYST_EN
            arm_q        <= arm_d;
`endif
        end
    end

    assign fcw_est    = fcw_q;
    assign period_t   = period_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q == S_MEASURE) || (state_q == S_DIVIDE);

endmodule

// File: doc/dds_freq_meter.md
Name: dds_freq_meter

Overview:
Receive-side counterpart of the DDS sine generator. Consumes the signed 16-bit sine amplitude stream and times N_CYC rising zero-crossings. A sequential restoring divider then recovers the frequency control word that produced the stream, so DDS output can be checked in closed loop against the programmed fcw. Sits downstream of the DDS output, in the same sys_clk domain.

Parameters:
LOG2_NCYC, 4, log2 of periods per measurement gate (N_CYC = 16)
CNT_W, 24, width of the sample counter; also sets the timeout limit 2^CNT_W-1
HYST, 256, hysteresis magnitude in LSBs; used only when DDS_FM_HYST_EN is defined

Ports:
sys_clk  input  1  clock
reset  input  1  synchronous, active-low reset
sin_amp  input  16  signed two's-complement sine sample
amp_valid  input  1  sample strobe; sin_amp is consumed only when high
fcw_est  output  32  recovered frequency control word
period_t  output  CNT_W  samples counted in the last completed gate
meas_valid  output  1  one-cycle pulse when fcw_est/period_t update
locked  output  1  high after a good measurement, cleared by timeout
timeout  output  1  one-cycle pulse when a gate overruns
busy  output  1  high in MEASURE or DIVIDE

Behaviour:
- Reset: on sys_clk edge with reset=0, all outputs go to 0, FSM goes to IDLE, prev_neg=0, counters=0.
- Rising crossing, evaluated only when amp_valid=1: prev_neg=1 and sin_amp[15]=0. prev_neg updates to sin_amp[15] on every valid sample in every state.
- FSM states:
  - IDLE: on a crossing, clear cnt and xcnt, go to MEASURE. The crossing sample is not counted.
  - MEASURE:
    - Each valid sample does cnt += 1.
    - On a crossing, xcnt += 1. When xcnt reaches N_CYC on that sample, latch T = cnt+1 and go to DIVIDE.
    - If cnt = 2^CNT_W-1 on a valid sample with no completion, pulse timeout, clear locked, go to IDLE.
  - DIVIDE: restoring long division Q = 2^(32+LOG2_NCYC) / T. Processes one numerator bit per cycle, MSB first. Takes exactly 33+LOG2_NCYC cycles (37 at default). Remainder is CNT_W+1 bits. Input samples are ignored except for prev_neg tracking. Then go to DONE.
  - DONE (1 cycle):
    - fcw_est = Q[31:0] if Q < 2^32, else 0xFFFFFFFF (saturate).
    - period_t = T, meas_valid = 1, locked = 1.
    - Go to IDLE. The next gate starts at the next crossing, so measurements are non-overlapping.
- Exact-period property: a stream with period P samples gives T = N_CYC*P and fcw_est = 2^32/P exactly.
- amp_valid low: cnt holds and no crossing is evaluated in any state.
- Reset mid-operation: checked first, overrides every state. Any in-flight measurement is discarded and no meas_valid is issued.
- busy = (state==MEASURE || state==DIVIDE).
- fcw_est/period_t hold their last value between pulses.

Optional Feature:
DDS_FM_HYST_EN.
- Defined: an arm flag is set when a valid sample satisfies sin_amp < -HYST. A rising crossing counts only while armed, and counting it clears arm. Arm resets to 0, which suppresses noise-induced double crossings.
- Not defined: crossings are the plain sign-change rule, with no arm logic and HYST unused.

Test Plan:
1. Reset, then ideal sine with fcw=0x01000000 (P=256), amp_valid=1 always -> meas_valid exactly 37 cycles after the 16th crossing past start; fcw_est=0x01000000, period_t=4096, locked=1.
2. fcw=0x00400000 (P=1024) -> period_t=16384, fcw_est=0x00400000; repeated gates give identical values.
3. Bench CNT_W=12, sin_amp held at +1000 after one crossing -> timeout pulses after 4095 valid samples, locked=0, meas_valid never asserts.
4. reset=0 for one cycle midway through DIVIDE -> next cycle all outputs 0, busy=0, FSM IDLE, no meas_valid; next gate measures correctly.
5. amp_valid high every other cycle, P=256 samples -> fcw_est=0x01000000, period_t=4096; clock count is irrelevant.
6. DDS_FM_HYST_EN, P=256 plus one -10/+10 glitch pair near each negative-going zero -> fcw_est=0x01000000. Without the macro, the same stream gives fcw_est roughly double.
